dense_backward_q_param: RTL and testbench

- Parametrised backward pass of a dense layer: computes q[n][r] = sum_c d[n][c] * W[r][c] for every batch lane n.
- Streams W from an external weight RAM through a raddr/rdata port, DATA_N weights per read.
- Sits in the training datapath and replaces fixed-size backward-q blocks.
- Generalised in lane count, matrix shape, bus width, data widths and RAM read latency.
- Adds fixed-point rescaling and a busy/valid run protocol.

---
 rtl/dense_backward_q_param_pkg.sv | 31 +++
 rtl/dense_backward_q_lane.sv | 83 ++++++++
 rtl/dense_backward_q_param.sv | 150 +++++++++++++++
 tb/tb_dense_backward_q_param.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/dense_backward_q_param_pkg.sv
// rtl/dense_backward_q_param_pkg.sv - training-datapath defaults, beat derivations and FSM state type
package dense_backward_q_param_pkg;

   localparam int DBQ_N_LANE     = 4;
   localparam int DBQ_ROWS       = 24;
   localparam int DBQ_COLS       = 200;
   localparam int DBQ_DATA_N     = 8;
   localparam int DBQ_D_WIDTH    = 24;
   localparam int DBQ_W_WIDTH    = 16;
   localparam int DBQ_Q_WIDTH    = 16;
   localparam int DBQ_FRAC_BITS  = 8;
   localparam int DBQ_ACC_WIDTH  = 48;
   localparam int DBQ_RD_LAT     = 1;
   localparam int DBQ_ADDR_WIDTH = 10;

   typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DRAIN, ST_DONE} dbq_state_t;

   function automatic int dbq_beats(input int rows, input int cols, input int data_n);
      return rows * cols / data_n;
   endfunction

   function automatic int dbq_bpr(input int cols, input int data_n);
      return cols / data_n;
   endfunction

   // Counter/index width that stays legal when the range collapses to one value.
   function automatic int dbq_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dense_backward_q_lane.sv
// rtl/dense_backward_q_lane.sv - one batch lane: DATA_N MACs, row accumulator, rescale/narrow, q rows
// DENSE_BACKWARD_Q_SAT_EN selects clamping narrowing; otherwise the shifted sum wraps to Q_WIDTH.
module dense_backward_q_lane
   import dense_backward_q_param_pkg::*;
#(
   parameter int ROWS      = DBQ_ROWS,
   parameter int COLS      = DBQ_COLS,
   parameter int DATA_N    = DBQ_DATA_N,
   parameter int D_WIDTH   = DBQ_D_WIDTH,
   parameter int W_WIDTH   = DBQ_W_WIDTH,
   parameter int Q_WIDTH   = DBQ_Q_WIDTH,
   parameter int FRAC_BITS = DBQ_FRAC_BITS,
   parameter int ACC_WIDTH = DBQ_ACC_WIDTH,
   parameter int CB_W      = dbq_idx_w(DBQ_COLS),
   parameter int ROW_W     = dbq_idx_w(DBQ_ROWS)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [COLS*D_WIDTH-1:0]     i_d,
   input  logic [DATA_N*W_WIDTH-1:0]   i_rdata,
   input  logic [CB_W-1:0]             i_cb,
   input  logic [ROW_W-1:0]            i_row,
   input  logic                        i_en,
   input  logic                        i_first,
   input  logic                        i_last,
   output logic [ROWS*Q_WIDTH-1:0]     o_q
);

   localparam int P_WIDTH = D_WIDTH + W_WIDTH;

   logic signed [ACC_WIDTH-1:0] r_acc;
   logic        [Q_WIDTH-1:0]   r_q [ROWS];
   logic signed [ACC_WIDTH-1:0] w_sum;
   logic signed [ACC_WIDTH-1:0] w_total;
   logic signed [ACC_WIDTH-1:0] w_shift;
   logic signed [D_WIDTH-1:0]   w_dj;
   logic signed [W_WIDTH-1:0]   w_wj;
   logic signed [P_WIDTH-1:0]   w_prod;
   logic        [Q_WIDTH-1:0]   w_narrow;

   always_comb begin
      w_sum  = '0;
      w_dj   = '0;
      w_wj   = '0;
      w_prod = '0;
      for (int j = 0; j < DATA_N; j++) begin
         w_dj   = i_d[(int'(i_cb) + j)*D_WIDTH +: D_WIDTH];
         w_wj   = i_rdata[j*W_WIDTH +: W_WIDTH];
         w_prod = P_WIDTH'(w_dj) * P_WIDTH'(w_wj);
         w_sum  = w_sum + ACC_WIDTH'(w_prod);
      end
   end

   // The first beat of a row loads, so no separate clear cycle is needed between rows.
   assign w_total = i_first ? w_sum : (r_acc + w_sum);
   assign w_shift = w_total >>> FRAC_BITS;

`ifdef DENSE_BACKWARD_Q_SAT_EN
   localparam logic signed [ACC_WIDTH-1:0] Q_MAX = {{(ACC_WIDTH-Q_WIDTH+1){1'b0}}, {(Q_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] Q_MIN = {{(ACC_WIDTH-Q_WIDTH+1){1'b1}}, {(Q_WIDTH-1){1'b0}}};
   assign w_narrow = (w_shift > Q_MAX) ? Q_MAX[Q_WIDTH-1:0] :
                     (w_shift < Q_MIN) ? Q_MIN[Q_WIDTH-1:0] : w_shift[Q_WIDTH-1:0];
`else
   logic w_unused_hi;
   assign w_unused_hi = ^w_shift[ACC_WIDTH-1:Q_WIDTH];
   assign w_narrow    = w_shift[Q_WIDTH-1:0];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
         for (int r = 0; r < ROWS; r++) r_q[r] <= '0;
      end else if (i_en) begin
         r_acc <= w_total;
         if (i_last) r_q[i_row] <= w_narrow;
      end
   end

   for (genvar g = 0; g < ROWS; g++) begin : g_out
      assign o_q[g*Q_WIDTH +: Q_WIDTH] = r_q[g];
   end

endmodule

// File: rtl/dense_backward_q_param.sv
// rtl/dense_backward_q_param.sv - dense-layer backward q = d x W^T, weights streamed from RAM
// Narrowing mode set by DENSE_BACKWARD_Q_SAT_EN (see dense_backward_q_lane).
module dense_backward_q_param
   import dense_backward_q_param_pkg::*;
#(
   parameter int N_LANE     = DBQ_N_LANE,
   parameter int ROWS       = DBQ_ROWS,
   parameter int COLS       = DBQ_COLS,
   parameter int DATA_N     = DBQ_DATA_N,
   parameter int D_WIDTH    = DBQ_D_WIDTH,
   parameter int W_WIDTH    = DBQ_W_WIDTH,
   parameter int Q_WIDTH    = DBQ_Q_WIDTH,
   parameter int FRAC_BITS  = DBQ_FRAC_BITS,
   parameter int ACC_WIDTH  = DBQ_ACC_WIDTH,
   parameter int RD_LAT     = DBQ_RD_LAT,
   parameter int ADDR_WIDTH = DBQ_ADDR_WIDTH
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               run,
   input  logic [N_LANE*COLS*D_WIDTH-1:0]     d,
   output logic [ADDR_WIDTH-1:0]              raddr,
   input  logic [DATA_N*W_WIDTH-1:0]          rdata,
   output logic                               busy,
   output logic                               valid,
   output logic [N_LANE*ROWS*Q_WIDTH-1:0]     q
);

   localparam int BEATS = dbq_beats(ROWS, COLS, DATA_N);
   localparam int BPR   = dbq_bpr(COLS, DATA_N);
   localparam int COL_W = dbq_idx_w(BPR);
   localparam int ROW_W = dbq_idx_w(ROWS);
   localparam int CB_W  = dbq_idx_w(COLS);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BEATS-1);

   dbq_state_t            r_state, w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_raddr;
   logic [COL_W-1:0]      r_col;
   logic [ROW_W-1:0]      r_row;
   logic [RD_LAT-1:0]     r_bv;
   logic                  r_busy, r_valid;
   logic                  w_busy_nxt, w_valid_nxt, w_issue;
   logic                  w_beat, w_first, w_last, w_final;
   logic [CB_W-1:0]       w_cb;

   // r_bv tracks which issued addresses have data arriving on rdata this cycle.
   assign w_beat  = run && r_bv[RD_LAT-1];
   assign w_first = (r_col == '0);
   assign w_last  = (r_col == COL_W'(BPR-1));
   assign w_final = w_beat && w_last && (r_row == ROW_W'(ROWS-1));
   assign w_cb    = CB_W'(r_col) * CB_W'(DATA_N);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_busy_nxt  = r_busy;
      w_valid_nxt = r_valid;
      w_issue     = 1'b0;
      if (!run) begin
         w_state_nxt = ST_IDLE;
         w_busy_nxt  = 1'b0;
         w_valid_nxt = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_issue     = 1'b1;
               w_busy_nxt  = 1'b1;
               w_state_nxt = (LAST_ADDR == '0) ? ST_DRAIN : ST_FETCH;
            end
            ST_FETCH: begin
               w_issue = 1'b1;
               if (r_raddr == LAST_ADDR) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: ;
            ST_DONE: begin
               w_busy_nxt  = 1'b0;
               w_valid_nxt = 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
         endcase
         if (w_final) w_state_nxt = ST_DONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_raddr <= '0;
         r_col   <= '0;
         r_row   <= '0;
         r_bv    <= '0;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_busy  <= w_busy_nxt;
         r_valid <= w_valid_nxt;
         if (!run) begin
            r_raddr <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_bv    <= '0;
         end else begin
            r_bv <= RD_LAT'({r_bv, w_issue});
            if (w_issue && (r_raddr != LAST_ADDR)) r_raddr <= r_raddr + ADDR_WIDTH'(1);
            if (w_beat) begin
               if (w_last) begin
                  r_col <= '0;
                  r_row <= r_row + ROW_W'(1);
               end else begin
                  r_col <= r_col + COL_W'(1);
               end
            end
         end
      end
   end

   assign raddr = r_raddr;
   assign busy  = r_busy;
   assign valid = r_valid;

   for (genvar n = 0; n < N_LANE; n++) begin : g_lane
      dense_backward_q_lane #(
         .ROWS      (ROWS),
         .COLS      (COLS),
         .DATA_N    (DATA_N),
         .D_WIDTH   (D_WIDTH),
         .W_WIDTH   (W_WIDTH),
         .Q_WIDTH   (Q_WIDTH),
         .FRAC_BITS (FRAC_BITS),
         .ACC_WIDTH (ACC_WIDTH),
         .CB_W      (CB_W),
         .ROW_W     (ROW_W)
      ) u_lane (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_d     (d[n*COLS*D_WIDTH +: COLS*D_WIDTH]),
         .i_rdata (rdata),
         .i_cb    (w_cb),
         .i_row   (r_row),
         .i_en    (w_beat),
         .i_first (w_first),
         .i_last  (w_last),
         .o_q     (q[n*ROWS*Q_WIDTH +: ROWS*Q_WIDTH])
      );
   end

endmodule

// File: tb/tb_dense_backward_q_param.sv
// tb/tb_dense_backward_q_param.sv - randomized bench against a plain-arithmetic dense backward-q model
module tb_dense_backward_q_param;

   localparam int NL = 2, R = 4, C = 8, DN = 4, DW = 24, WW = 16, QW = 16, AW = 48, ADW = 4;
   localparam int BEATS = R*C/DN;
   localparam int FRAC_A = 0, LAT_A = 1, FRAC_B = 4, LAT_B = 3;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 run = 1'b0;
   logic [NL*C*DW-1:0]   d_vec = '0;
   logic [ADW-1:0]       raddr_a, raddr_b;
   logic [DN*WW-1:0]     rdata_a, rdata_b;
   logic                 busy_a, valid_a, busy_b, valid_b;
   logic [NL*R*QW-1:0]   q_a, q_b;

   int                   dm [NL][C];
   int                   wm [R][C];
   logic [DN*WW-1:0]     wmem [2**ADW];
   logic [ADW-1:0]       ap_a [LAT_A];
   logic [ADW-1:0]       ap_b [LAT_B];
   int                   n_checks = 0;
   int                   n_fail = 0;

   always #5 clk = ~clk;

   // Weight RAMs with RD_LAT registered address stages.
   always @(posedge clk) begin
      ap_a[0] <= raddr_a;
      for (int i = 1; i < LAT_A; i++) ap_a[i] <= ap_a[i-1];
      ap_b[0] <= raddr_b;
      for (int i = 1; i < LAT_B; i++) ap_b[i] <= ap_b[i-1];
   end
   assign rdata_a = wmem[ap_a[LAT_A-1]];
   assign rdata_b = wmem[ap_b[LAT_B-1]];

   dense_backward_q_param #(
      .N_LANE(NL), .ROWS(R), .COLS(C), .DATA_N(DN), .D_WIDTH(DW), .W_WIDTH(WW), .Q_WIDTH(QW),
      .FRAC_BITS(FRAC_A), .ACC_WIDTH(AW), .RD_LAT(LAT_A), .ADDR_WIDTH(ADW)
   ) u_dut_a (
      .clk(clk), .rst_n(rst_n), .run(run), .d(d_vec), .raddr(raddr_a), .rdata(rdata_a),
      .busy(busy_a), .valid(valid_a), .q(q_a)
   );

   dense_backward_q_param #(
      .N_LANE(NL), .ROWS(R), .COLS(C), .DATA_N(DN), .D_WIDTH(DW), .W_WIDTH(WW), .Q_WIDTH(QW),
      .FRAC_BITS(FRAC_B), .ACC_WIDTH(AW), .RD_LAT(LAT_B), .ADDR_WIDTH(ADW)
   ) u_dut_b (
      .clk(clk), .rst_n(rst_n), .run(run), .d(d_vec), .raddr(raddr_b), .rdata(rdata_b),
      .busy(busy_b), .valid(valid_b), .q(q_b)
   );

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint exp_q(input int n, input int r, input int frac);
      longint s, v;
      s = 0;
      for (int c = 0; c < C; c++) s += longint'(dm[n][c]) * longint'(wm[r][c]);
      v = s >>> frac;
`ifdef DENSE_BACKWARD_Q_SAT_EN
      if (v > (longint'(1) <<< (QW-1)) - 1) v = (longint'(1) <<< (QW-1)) - 1;
      else if (v < -(longint'(1) <<< (QW-1))) v = -(longint'(1) <<< (QW-1));
`endif
      return v & ((longint'(1) <<< QW) - 1);
   endfunction

   // 0 identity, 1 random, 2 large positive, 3 large negative, 4 small negative products
   task automatic fill(input int mode);
      for (int n = 0; n < NL; n++)
         for (int c = 0; c < C; c++)
            case (mode)
               0: dm[n][c] = (n == 0) ? c + 1 : -(c + 1);
               1: dm[n][c] = int'($urandom) >>> 8;
               2: dm[n][c] = 32'h0010_0000;
               3: dm[n][c] = -32'sh0010_0000;
               default: dm[n][c] = -3;
            endcase
      for (int r = 0; r < R; r++)
         for (int c = 0; c < C; c++)
            case (mode)
               0: wm[r][c] = (r == c) ? 1 : 0;
               1: wm[r][c] = int'($urandom) >>> 16;
               2, 3: wm[r][c] = 32'h7FFF;
               default: wm[r][c] = 2;
            endcase
      for (int n = 0; n < NL; n++)
         for (int c = 0; c < C; c++) d_vec[(n*C+c)*DW +: DW] = DW'(dm[n][c]);
      for (int f = 0; f < R*C; f++) wmem[f/DN][(f%DN)*WW +: WW] = WW'(wm[f/C][f%C]);
   endtask

   task automatic check_q(input string tag);
      for (int n = 0; n < NL; n++)
         for (int r = 0; r < R; r++) begin
            chk($sformatf("%s_qa[%0d][%0d]", tag, n, r), longint'(q_a[(n*R+r)*QW +: QW]), exp_q(n, r, FRAC_A));
            chk($sformatf("%s_qb[%0d][%0d]", tag, n, r), longint'(q_b[(n*R+r)*QW +: QW]), exp_q(n, r, FRAC_B));
         end
   endtask

   task automatic check_q_zero(input string tag);
      for (int i = 0; i < NL*R; i++) begin
         chk($sformatf("%s_qa_zero%0d", tag, i), longint'(q_a[i*QW +: QW]), 0);
         chk($sformatf("%s_qb_zero%0d", tag, i), longint'(q_b[i*QW +: QW]), 0);
      end
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_valid_a"}, longint'(valid_a), 0);
      chk({tag, "_busy_a"},  longint'(busy_a),  0);
      chk({tag, "_raddr_a"}, longint'(raddr_a), 0);
      chk({tag, "_valid_b"}, longint'(valid_b), 0);
      chk({tag, "_busy_b"},  longint'(busy_b),  0);
      chk({tag, "_raddr_b"}, longint'(raddr_b), 0);
   endtask

   // Full pass from IDLE: e counts edges after t0, outputs sampled 1 time unit after each edge.
   task automatic run_pass(input string tag);
      longint ea;
      @(negedge clk);
      run = 1'b1;
      for (int e = 0; e <= BEATS + LAT_B + 2; e++) begin
         @(posedge clk);
         #1;
         ea = (e + 1 < BEATS) ? e + 1 : BEATS - 1;
         chk($sformatf("%s_raddr_a_e%0d", tag, e), longint'(raddr_a), ea);
         chk($sformatf("%s_raddr_b_e%0d", tag, e), longint'(raddr_b), ea);
         chk($sformatf("%s_valid_a_e%0d", tag, e), longint'(valid_a), longint'(e >= BEATS + LAT_A));
         chk($sformatf("%s_busy_a_e%0d",  tag, e), longint'(busy_a),  longint'(e <  BEATS + LAT_A));
         chk($sformatf("%s_valid_b_e%0d", tag, e), longint'(valid_b), longint'(e >= BEATS + LAT_B));
         chk($sformatf("%s_busy_b_e%0d",  tag, e), longint'(busy_b),  longint'(e <  BEATS + LAT_B));
      end
      check_q(tag);
      @(negedge clk);
      run = 1'b0;
      @(posedge clk);
      #1;
      check_idle({tag, "_stop"});
      check_q({tag, "_hold"});
   endtask

   initial begin
      fill(0);
      repeat (3) @(posedge clk);
      #1;
      check_idle("reset");
      check_q_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      fill(0); run_pass("ident");
      for (int i = 0; i < 3; i++) begin
         fill(1);
         run_pass($sformatf("rand%0d", i));
      end
      fill(2); run_pass("satpos");
      fill(3); run_pass("satneg");
      fill(4); run_pass("negprod");

      fill(1);
      @(negedge clk);
      run = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      run = 1'b0;
      @(posedge clk);
      #1;
      check_idle("abort");
      run_pass("rerun");

      fill(1);
      @(negedge clk);
      run = 1'b1;
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_idle("midrst");
      check_q_zero("midrst");
      run = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      run_pass("after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
